// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_pkg : shared fetch-path constants and fetch FSM state encoding        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef enum logic [0:0] {
    ST_RESET_HOLD = 1'b0,
    ST_FETCH      = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +----------------------------------------------------------------------------+
// | fetch_fifo : instruction queue with registered head/valid and flush        |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int           PW       = $clog2(DEPTH);
  localparam logic [PW:0]  FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == FULL_CNT);
    do_pop  = pop && valid_q;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    // The write slot becomes the new head only when the queue drains to it
    head_d  = (do_push && (wr_q == rd_d)) ? push_data : mem_q[rd_d];
    valid_d = (count_d != '0);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      valid_d = 1'b0;
      head_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign valid = valid_q;
  assign head  = head_q;
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

`default_nettype wire

// File: rtl/mips_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | mips_fetch_unit : credit-based instruction fetch with redirect and drop    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc4,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);

  localparam int          CW           = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(QDEPTH);

  fetch_state_e     state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [31:0]      resp_pc_q, resp_pc_d;

  logic             grant, push, pop, resp_drop, credit_ok;
  logic [31:0]      redir_aligned;
  logic [CW-1:0]    occ, occ_next;
  logic             fifo_valid;
  logic [63:0]      fifo_head;

  always_comb begin
    grant         = req_q && imem_gnt;
    pop           = fifo_valid && id_ready;
    resp_drop     = (drop_q != '0);
    push          = imem_rvalid && !resp_drop && !redirect;
    redir_aligned = redirect_pc & 32'hFFFF_FFFC;

    case (state_q)
      ST_RESET_HOLD: state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH;
      default:       state_d = ST_RESET_HOLD;
    endcase

    out_d = out_q + CW'(grant) - CW'(imem_rvalid);

    // Everything still in flight after this cycle belongs to the old path
    if (redirect) begin
      drop_d = out_d;
    end else if (imem_rvalid && resp_drop) begin
      drop_d = drop_q - 1'b1;
    end else begin
      drop_d = drop_q;
    end

    occ_next = redirect ? '0 : (occ + CW'(push) - CW'(pop));

    if (redirect) begin
      addr_d = redir_aligned;
    end else if (grant) begin
      addr_d = addr_q + 32'd4;
    end else begin
      addr_d = addr_q;
    end

    // First surviving response after a redirect is the one fetched at redirect_pc
    if (redirect) begin
      resp_pc_d = redir_aligned;
    end else if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end else begin
      resp_pc_d = resp_pc_q;
    end

    credit_ok = (({1'b0, occ_next} + {1'b0, out_d}) < CREDIT_LIMIT);

    if (req_q && !imem_gnt && !redirect) begin
      req_d = 1'b1;
    end else begin
      req_d = (state_d == ST_FETCH) && credit_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET_HOLD;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      resp_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      resp_pc_q <= resp_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, resp_pc_q + 32'd4}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (occ)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = fifo_valid;
  assign id_instr  = fifo_head[63:32];
  assign id_pc4    = fifo_head[31:0];

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mips_fetch_unit : vector table, directed corner sequences, random run   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mips_fetch_unit;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_PC (RPC),
    .QDEPTH   (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  mreq_t       mq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          lat_fix = 1;
  int          delivered = 0;
  int          grants = 0;
  logic [31:0] exp_pc;
  logic [31:0] first_pc4;
  logic        saw_first;
  logic        chk_empty;
  logic        hold_prev;
  logic [31:0] hold_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mkv(input logic g, input logic r, input logic rd, input logic [31:0] rp,
                               input logic eq, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rdy = r; v.redir = rd; v.rpc = rp;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_to(input string name);
    n_total++;
    $display("FAIL %s: got no event within bound, expected one", name);
  endtask

  // One clock: check the sampled outputs, play the memory and ID side, advance.
  task automatic step(input logic g, input logic r, input logic rd, input logic [31:0] rp);
    mreq_t nr;
    logic  rv;
    int    lat;
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    chk("credit_bound", 32'(mq.size() <= QD), 32'd1);
    if (chk_empty) chk("flush_empty", id_valid, 1'b0);
    if (hold_prev) begin
      chk("hold_req", imem_req, 1'b1);
      chk("hold_addr", imem_addr, hold_addr);
    end
    if (id_valid && r) begin
      chk("deliver_pc4", id_pc4, exp_pc + 32'd4);
      chk("deliver_instr", id_instr, instr_of(exp_pc));
      if (!saw_first) begin
        first_pc4 = id_pc4;
        saw_first = 1'b1;
      end
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    imem_gnt    = g;
    id_ready    = r;
    redirect    = rd;
    redirect_pc = rp;
    rv          = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? instr_of(mq[0].addr) : 32'hDEAD_BEEF;
    if (rv) void'(mq.pop_front());
    if (imem_req && g) begin
      lat     = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      nr.addr = imem_addr;
      nr.due  = cyc + lat;
      mq.push_back(nr);
      grants++;
    end
    if (rd) begin
      exp_pc    = rp & 32'hFFFF_FFFC;
      saw_first = 1'b0;
    end
    chk_empty = rd;
    hold_prev = imem_req && !g && !rd;
    hold_addr = imem_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mq.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    reset     = 1'b0;
    exp_pc    = RPC;
    saw_first = 1'b1;
    chk_empty = 1'b0;
    hold_prev = 1'b0;
  endtask

  initial begin
    vec_t tv[10];
    logic found;
    logic has10;

    // Sequential fetch from reset, then a redirect that wraps the PC.
    tv[0] = mkv(1, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0);
    tv[1] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);
    tv[2] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0);
    tv[3] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h4);
    tv[4] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h8);
    tv[5] = mkv(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h0000_0010, 1, 32'hC);
    tv[6] = mkv(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
    tv[7] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);
    tv[8] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0);
    tv[9] = mkv(1, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h4);

    do_reset();
    lat_fix = 1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_req", i), imem_req, tv[i].e_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), id_valid, tv[i].e_valid);
      if (tv[i].e_valid) begin
        chk($sformatf("tbl%0d_pc4", i), id_pc4, tv[i].e_pc4);
        chk($sformatf("tbl%0d_instr", i), id_instr, instr_of(tv[i].e_pc4 - 32'd4));
      end
      step(tv[i].gnt, tv[i].rdy, tv[i].redir, tv[i].rpc);
    end

    // ID stalled: credits stop requests at exactly QDEPTH grants.
    do_reset();
    lat_fix = 1;
    grants  = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_grants", grants, QD);
    chk("stall_req_off", imem_req, 1'b0);
    chk("stall_head_valid", id_valid, 1'b1);
    delivered = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_resume_progress", 32'(delivered >= 12), 32'd1);

    // Redirect with responses for 0x10 and 0x14 still in flight.
    do_reset();
    lat_fix = 3;
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_req && imem_addr == 32'h14) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    if (!found) fail_to("drop_reach_0x14");
    else begin
      has10 = 1'b0;
      foreach (mq[k]) if (mq[k].addr == 32'h10) has10 = 1'b1;
      chk("drop_0x10_in_flight", has10, 1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h400);
      for (int i = 0; i < 40 && !saw_first; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      if (!saw_first) fail_to("drop_first_delivery");
      else chk("drop_first_pc4", first_pc4, 32'h404);
    end

    // Grant withheld on 0x20, redirect lands while the request is pending.
    do_reset();
    lat_fix = 1;
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_req && imem_addr == 32'h20) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    if (!found) fail_to("hold_reach_0x20");
    else begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("nogrant_addr_held", imem_addr, 32'h20);
      chk("nogrant_req_held", imem_req, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h800);
      chk("withdraw_req", imem_req, 1'b1);
      chk("withdraw_addr", imem_addr, 32'h800);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("withdraw_addr_held", imem_addr, 32'h800);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Redirect, pop and response all in the same cycle.
    do_reset();
    lat_fix = 1;
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (id_valid && mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    if (!found) fail_to("rpr_reach");
    else begin
      step(1'b1, 1'b1, 1'b1, 32'h200);
      chk("rpr_queue_empty", id_valid, 1'b0);
      for (int i = 0; i < 40 && !saw_first; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      if (!saw_first) fail_to("rpr_first_delivery");
      else chk("rpr_first_pc4", first_pc4, 32'h204);
    end

    // Random traffic against the stream model, with a reset mid-run.
    do_reset();
    lat_fix   = 0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        g, r, rd;
      logic [31:0] rp;
      if (i == 1500) do_reset();
      g  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 99) < 3);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(g, r, rd, rp);
    end
    chk("rand_progress", 32'(delivered > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4, instruction queue depth; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned; bits [1:0] = 0.
REQ-007 imem_gnt  input  1  memory accepts request this cycle; handshake completes on imem_req & imem_gnt.
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, latency >= 1 cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 id_valid  output  1  queue head valid toward ID.
REQ-011 id_instr  output  32  queue head instruction.
REQ-012 id_pc4  output  32  queue head fetch address + 4.
REQ-013 id_ready  input  1  ID accepts head; pop on id_valid & id_ready; deasserted on load-use stall.
REQ-014 redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).

Function
REQ-016 imem_req, imem_addr shall be driven from registers only; no combinational path from any input.
REQ-017 Credits: imem_req shall be 1 only when occupancy + outstanding < QDEPTH and not in RESET_HOLD.
REQ-018 On grant, fetch PC shall advance by 4 (mod 2^32, wraps silently) and outstanding shall increment.
REQ-019 imem_req/imem_addr shall hold stable while imem_req=1 and imem_gnt=0.
REQ-020 Response with drop_cnt = 0 shall push {imem_rdata, addr+4} into the queue; id_valid rises the next cycle (1-cycle latency, no bypass).
REQ-021 Each response shall decrement outstanding; if drop_cnt > 0, it decrements drop_cnt and the data is discarded.
REQ-022 Queue shall never overflow by construction; a response arriving with queue full shall not occur, and assertion shall flag it.
REQ-023 Push and pop in the same cycle shall leave occupancy unchanged.
REQ-024 redirect shall, next cycle: empty queue (id_valid=0), fetch PC = redirect_pc, drop_cnt = outstanding (including any request granted and any response arriving in the redirect cycle, excluding responses consumed).
REQ-025 Redirect coinciding with pop: redirect wins; popped entry is considered delivered.
REQ-026 Redirect during an ungranted request: request is withdrawn, reissued with redirect_pc the following cycle.
REQ-027 Back-to-back redirects: the later redirect_pc wins; drop_cnt recomputed each time.
REQ-028 New requests may issue while drop_cnt > 0, subject to REQ-017 (dropped responses still consume credits).
REQ-029 FSM: RESET_HOLD (one cycle after reset release) -> FETCH; FETCH -> FETCH always; no other states.

Reset
REQ-030 While reset=1: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc4=0, occupancy=outstanding=drop_cnt=0, state=RESET_HOLD.
REQ-031 Reset asserted mid-operation shall abandon all outstanding responses; memory is reset by the same signal.
REQ-032 First imem_req=1 with imem_addr=RESET_PC shall occur in the second cycle after reset deassertion.

Structure
REQ-033 Shared package mips_pkg shall hold RESET_PC default, instruction width (32), and the fetch FSM state enum.
REQ-034 Queue shall be one sub-module, fetch_fifo (parameterized width 64, depth QDEPTH, registered outputs).
REQ-035 Counters outstanding and drop_cnt shall be $clog2(QDEPTH)+1 bits wide.

Verification
REQ-036 Reset release, imem_gnt=1, 1-cycle latency, id_ready=1 -> addresses 0,4,8,... in order; id_pc4 = 4,8,12.
REQ-037 id_ready=0 for 10 cycles -> exactly QDEPTH=4 grants, then imem_req=0; id_ready=1 resumes, no loss or duplication.
REQ-038 Two outstanding at 0x10,0x14, redirect to 0x400 -> both responses dropped; first delivered id_pc4 = 0x404.
REQ-039 imem_gnt=0 for 3 cycles on addr 0x20 -> imem_addr held 0x20; redirect in cycle 2 -> next request addr = redirect_pc.
REQ-040 Redirect + pop + rvalid same cycle -> queue empty next cycle, drop_cnt excludes nothing wrongly; no stale instruction delivered.
REQ-041 PC 0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000, id_pc4 = 0x0000_0000.
